opamp_az_sequencer: RTL and testbench
=====================================

# opamp_az_sequencer

Digital control sequencer for the on-chip analog op-amp macro. It generates non-overlapping two-phase chopper clocks and runs an auto-zero calibration sequence that drives the analog switch controls (input chop, offset-storage, output connect). It sits in the digital domain of the opamp tile, fed from `ui_in`/`uio_in` through the top wrapper, with its switch outputs routed to the analog macro and mirrored on `uo_out` for observation.

## Interface
- `DIV_W`, 8: width of the chop half-period register.
- `DEAD_W`, 4: width of the dead-time register.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  block enable; 0 forces all switch outputs low.
- `cfg_we`  input  1  config write strobe, one write per cycle.
- `cfg_addr`  input  2  register select: 0 DIV, 1 DEAD, 2 AZ_LEN, 3 CTRL (bit0 `chop_en`).
- `cfg_wdata`  input  8  write data; DEAD uses the low `DEAD_W` bits.
- `cfg_rdata`  output  8  combinational readback of the addressed register.
- `az_req`  input  1  auto-zero request, level-sampled.
- `phi1`, `phi2`  output  1 each  chopper phases; never simultaneously high.
- `sw_az`  output  1  offset-storage switch, high during zeroing.
- `sw_out`  output  1  output connect switch.
- `az_busy`  output  1  auto-zero sequence in progress.
- `az_done`  output  1  one-cycle pulse at sequence completion.
- `chop_sync`  output  1  one-cycle pulse on each entry to PH1.

## Operation
- Reset values: all outputs 0. DIV=8, DEAD=2, AZ_LEN=16, CTRL=0.
- Register value 0 in DIV, DEAD or AZ_LEN is treated as 1. A dead time of at least 1 cycle is always guaranteed.
- All outputs are registered (`cfg_rdata` excepted).
- Chopper FSM: C_IDLE → C_PH1 (DIV cycles, `phi1`=1) → C_GAP1 (DEAD cycles) → C_PH2 (DIV cycles, `phi2`=1) → C_GAP2 (DEAD cycles) → C_PH1, and so on.
  - It leaves C_IDLE when `en`=1, `chop_en`=1 and the AZ FSM is idle.
  - The down-counter reloads from the live register at each state entry. DIV/DEAD writes therefore take effect at the next phase boundary.
  - `chop_en`=0 or `en`=0 returns the FSM to C_IDLE on the next edge from any state; phases drop immediately.
- AZ FSM: A_IDLE → A_DISC (DEAD cycles) → A_ZERO (AZ_LEN cycles, `sw_az`=1) → A_RECON (DEAD cycles) → A_IDLE.
  - `az_req` is accepted in A_IDLE only when `en`=1.
  - On accept, the chopper is forced to C_IDLE and `sw_out`=0; both take effect at the same edge that sets `az_busy`.
  - DEAD and AZ_LEN are shadowed at the accept edge. Writes during the sequence do not alter it.
  - `az_req` while busy is ignored; no queuing.
  - On leaving A_RECON: `az_done`=1 for one cycle, `az_busy`=0, `sw_out`=1. If `chop_en`, the chopper enters C_PH1 on that same edge (`phi1`=1, `chop_sync`=1).
- `sw_out` = `en` and not busy, registered. It rises 1 cycle after `en` rises.
- If `en` falls mid-sequence, the sequence aborts: next edge all FSMs idle, all outputs 0, no `az_done`.
- Write with `az_req` accepted on the same edge: the shadow captures the pre-write value.

## Timing
- `en` sampled high at edge 0 (with `chop_en`=1) → `phi1`=1 and `chop_sync`=1 from edge 1.
- Chop period is 2·(DIV+DEAD) cycles.
- Auto-zero: `sw_out` is low for exactly 2·DEAD+AZ_LEN cycles. `sw_az` rises DEAD cycles after accept and falls DEAD cycles before `az_done`.
- `rst` asserted at any edge → all outputs 0 and registers at defaults at that edge, regardless of state.

## Test plan
- Reset then `en`=1, CTRL=1, DIV=3, DEAD=2 → `phi1` high in cycles 1–3, gap 4–5, `phi2` high 6–8, gap 9–10, `phi1` again at 11. `chop_sync` at 1 and 11. `phi1`&`phi2` never both high.
- DEAD=2, AZ_LEN=4, `az_req` accepted at edge k → `phi1`/`phi2`/`sw_out`=0 from k. `sw_az`=1 during k+2..k+5. `az_done` and `sw_out`=1 at k+8, with `phi1`=1 at k+8.
- Write DIV=5 during C_PH1 with DIV=3 → current phase still lasts 3 cycles; the next PH2 lasts 5.
- `az_req` held high through a sequence → exactly one `az_done`; a second sequence is accepted only after A_IDLE is re-entered. Write AZ_LEN=10 mid-sequence → current zeroing still lasts 4 cycles.
- `en` dropped during A_ZERO → next edge `sw_az`=`sw_out`=`az_busy`=0, and `az_done` never pulses.
- `rst` pulsed during C_PH2 → all outputs 0; `cfg_rdata` reads 8/2/16/0 at addresses 0–3.

Source files
------------

// File: rtl/opamp_az_sequencer.sv
// opamp_az_sequencer: two-phase non-overlapping chopper clocks
// plus auto-zero switch sequencing for the analog op-amp macro.
module opamp_az_sequencer #(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       az_req,
  output logic       phi1,
  output logic       phi2,
  output logic       sw_az,
  output logic       sw_out,
  output logic       az_busy,
  output logic       az_done,
  output logic       chop_sync
);

  localparam int CW = (DIV_W > 8) ? DIV_W : 8;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    C_IDLE, C_PH1, C_GAP1, C_PH2, C_GAP2
  } chop_st_t;

  typedef enum logic [1:0] {
    A_IDLE, A_DISC, A_ZERO, A_RECON
  } az_st_t;

  chop_st_t          c_st;
  az_st_t            a_st;
  logic [CW-1:0]     c_cnt;
  logic [CW-1:0]     a_cnt;
  logic [DIV_W-1:0]  div_r;
  logic [DEAD_W-1:0] dead_r;
  logic [7:0]        azlen_r;
  logic              chop_en;
  logic [CW-1:0]     dead_sh;
  logic [CW-1:0]     azl_sh;
  logic              en_q;

  logic [CW-1:0] div_len;
  logic [CW-1:0] dead_len;
  logic [CW-1:0] az_len;
  logic          az_start;
  logic          az_end;
  logic          c_hold;

  // Zero-valued registers behave as 1; the dead time is never skipped.
  always_comb begin
    div_len  = (div_r == '0) ? ONE : CW'(div_r);
    dead_len = (dead_r == '0) ? ONE : CW'(dead_r);
    az_len   = (azlen_r == '0) ? ONE : CW'(azlen_r);
    az_start = (a_st == A_IDLE) && az_req;
    az_end   = (a_st == A_RECON) && (a_cnt == '0);
    c_hold   = az_start || ((a_st != A_IDLE) && !az_end);
  end

  // Configuration readback, combinational on the address.
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0: cfg_rdata = 8'(div_r);
      2'd1: cfg_rdata = 8'(dead_r);
      2'd2: cfg_rdata = azlen_r;
      2'd3: cfg_rdata = {7'b0, chop_en};
    endcase
  end

  // Configuration register writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= DIV_W'(8);
      dead_r  <= DEAD_W'(2);
      azlen_r <= 8'd16;
      chop_en <= 1'b0;
    end else if (cfg_we) begin
      unique case (cfg_addr)
        2'd0: div_r   <= DIV_W'(cfg_wdata);
        2'd1: dead_r  <= DEAD_W'(cfg_wdata);
        2'd2: azlen_r <= cfg_wdata;
        2'd3: chop_en <= cfg_wdata[0];
      endcase
    end
  end

  // Auto-zero and chopper FSMs; AZ owns the switches while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      dead_sh <= ONE;
      azl_sh  <= ONE;
    end else if (en && az_start) begin
      dead_sh <= dead_len;
      azl_sh  <= az_len;
    end
    if (rst || !en) begin
      c_st      <= C_IDLE;
      a_st      <= A_IDLE;
      c_cnt     <= '0;
      a_cnt     <= '0;
      en_q      <= 1'b0;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      sw_az     <= 1'b0;
      sw_out    <= 1'b0;
      az_busy   <= 1'b0;
      az_done   <= 1'b0;
      chop_sync <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      az_done   <= 1'b0;
      chop_sync <= 1'b0;
      unique case (a_st)
        A_IDLE: begin
          if (az_req) begin
            a_st    <= A_DISC;
            a_cnt   <= dead_len - ONE;
            az_busy <= 1'b1;
            sw_out  <= 1'b0;
          end else begin
            sw_out <= 1'b1;
          end
        end
        A_DISC: begin
          if (a_cnt == '0) begin
            a_st  <= A_ZERO;
            a_cnt <= azl_sh - ONE;
            sw_az <= 1'b1;
          end else begin
            a_cnt <= a_cnt - ONE;
          end
        end
        A_ZERO: begin
          if (a_cnt == '0) begin
            a_st  <= A_RECON;
            a_cnt <= dead_sh - ONE;
            sw_az <= 1'b0;
          end else begin
            a_cnt <= a_cnt - ONE;
          end
        end
        A_RECON: begin
          if (a_cnt == '0) begin
            a_st    <= A_IDLE;
            az_busy <= 1'b0;
            az_done <= 1'b1;
            sw_out  <= 1'b1;
          end else begin
            a_cnt <= a_cnt - ONE;
          end
        end
      endcase
      if (c_hold || !chop_en) begin
        c_st <= C_IDLE;
        phi1 <= 1'b0;
        phi2 <= 1'b0;
      end else begin
        unique case (c_st)
          C_IDLE: begin
            if (en_q) begin
              c_st      <= C_PH1;
              c_cnt     <= div_len - ONE;
              phi1      <= 1'b1;
              chop_sync <= 1'b1;
            end
          end
          C_PH1: begin
            if (c_cnt == '0) begin
              c_st  <= C_GAP1;
              c_cnt <= dead_len - ONE;
              phi1  <= 1'b0;
            end else begin
              c_cnt <= c_cnt - ONE;
            end
          end
          C_GAP1: begin
            if (c_cnt == '0) begin
              c_st  <= C_PH2;
              c_cnt <= div_len - ONE;
              phi2  <= 1'b1;
            end else begin
              c_cnt <= c_cnt - ONE;
            end
          end
          C_PH2: begin
            if (c_cnt == '0) begin
              c_st  <= C_GAP2;
              c_cnt <= dead_len - ONE;
              phi2  <= 1'b0;
            end else begin
              c_cnt <= c_cnt - ONE;
            end
          end
          C_GAP2: begin
            if (c_cnt == '0) begin
              c_st      <= C_PH1;
              c_cnt     <= div_len - ONE;
              phi1      <= 1'b1;
              chop_sync <= 1'b1;
            end else begin
              c_cnt <= c_cnt - ONE;
            end
          end
          default: begin
            c_st <= C_IDLE;
            phi1 <= 1'b0;
            phi2 <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opamp_az_sequencer.sv
// tb_opamp_az_sequencer: directed stimulus with a queued
// scoreboard drained by a negedge monitor.
module tb_opamp_az_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, cfg_we, az_req;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata, cfg_rdata;
  logic       phi1, phi2, sw_az, sw_out;
  logic       az_busy, az_done, chop_sync;
  logic [15:0] obs;

  localparam logic [6:0] P1 = 7'h40;
  localparam logic [6:0] P2 = 7'h20;
  localparam logic [6:0] AZ = 7'h10;
  localparam logic [6:0] SO = 7'h08;
  localparam logic [6:0] BZ = 7'h04;
  localparam logic [6:0] DN = 7'h02;
  localparam logic [6:0] CS = 7'h01;
  localparam logic [6:0] NO = 7'h00;

  always #5 clk = ~clk;

  opamp_az_sequencer dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .az_req(az_req),
    .phi1(phi1), .phi2(phi2),
    .sw_az(sw_az), .sw_out(sw_out),
    .az_busy(az_busy), .az_done(az_done),
    .chop_sync(chop_sync)
  );

  assign obs = {cfg_rdata, 1'b0, phi1, phi2, sw_az,
                sw_out, az_busy, az_done, chop_sync};

  typedef struct {
    string       nm;
    logic [15:0] m;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string nm,
                      input logic [15:0] m,
                      input logic [15:0] v);
    exp_t e;
    e.nm = nm;
    e.m  = m;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic [6:0] v);
    @(posedge clk);
    #1;
    push(nm, 16'h007f, {9'h0, v});
  endtask

  task automatic rd(input string nm, input logic [1:0] a,
                    input logic [7:0] v);
    cfg_addr = a;
    push(nm, 16'hff00, {v, 8'h00});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d,
                    input string nm, input logic [6:0] v);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step(nm, v);
    cfg_we    = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n_tests++;
      if (phi1 === 1'b1 && phi2 === 1'b1) begin
        n_fail++;
        $display("FAIL overlap: phi1=%b phi2=%b want not both 1",
                 phi1, phi2);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          n_fail++;
          $display("FAIL %s: got %h want %h at %0t",
                   e.nm, obs & e.m, e.v & e.m, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; az_req = 1'b0;
    cfg_addr = 2'd0; cfg_wdata = 8'd0;
    step("rst0", NO);
    step("rst1", NO);
    rst = 1'b0;

    wr(2'd3, 8'd1, "cfg_ctrl", NO);
    wr(2'd0, 8'd3, "cfg_div", NO);
    wr(2'd1, 8'd2, "cfg_dead", NO);

    en = 1'b1;
    step("en_e0", SO);
    step("ph1_e1", P1 | CS | SO);
    repeat (2) step("ph1", P1 | SO);
    repeat (2) step("gap1", SO);
    repeat (3) step("ph2", P2 | SO);
    repeat (2) step("gap2", SO);
    step("ph1_e11", P1 | CS | SO);

    wr(2'd0, 8'd5, "divw_ph1", P1 | SO);
    step("divw_ph1b", P1 | SO);
    repeat (2) step("divw_gap1", SO);
    repeat (5) step("divw_ph2", P2 | SO);
    repeat (2) step("divw_gap2", SO);
    step("divw_ph1n", P1 | CS | SO);

    wr(2'd2, 8'd4, "azl4", P1 | SO);
    wr(2'd0, 8'd3, "div3", P1 | SO);
    az_req = 1'b1;
    step("az_acc", BZ);
    az_req = 1'b0;
    step("az_disc", BZ);
    repeat (4) step("az_zero", AZ | BZ);
    repeat (2) step("az_recon", BZ);
    step("az_done", DN | SO | P1 | CS);
    repeat (2) step("az_ph1", P1 | SO);
    step("az_gap1", SO);

    az_req = 1'b1;
    step("hold_acc", BZ);
    wr(2'd2, 8'd10, "azl10_mid", BZ);
    repeat (4) step("hold_zero4", AZ | BZ);
    repeat (2) step("hold_recon", BZ);
    step("hold_done", DN | SO | P1 | CS);
    step("hold_reacc", BZ);
    az_req = 1'b0;
    step("ab_disc", BZ);
    repeat (2) step("ab_zero", AZ | BZ);
    en = 1'b0;
    step("abort", NO);
    rd("rd_azl", 2'd2, 8'd10);
    step("abort_nodone", NO);
    rd("rd_div", 2'd0, 8'd3);
    step("abort_nodone", NO);
    step("abort_nodone", NO);

    en = 1'b1;
    step("re_e0", SO);
    step("re_ph1", P1 | CS | SO);
    repeat (2) step("re_ph1", P1 | SO);
    repeat (2) step("re_gap1", SO);
    repeat (2) step("re_ph2", P2 | SO);
    rst = 1'b1;
    step("rst_ph2", NO);
    rst = 1'b0;
    en  = 1'b0;
    rd("rd_rst_div", 2'd0, 8'd8);
    step("rst_idle", NO);
    rd("rd_rst_dead", 2'd1, 8'd2);
    step("rst_idle", NO);
    rd("rd_rst_azl", 2'd2, 8'd16);
    step("rst_idle", NO);
    rd("rd_rst_ctrl", 2'd3, 8'd0);
    step("rst_idle", NO);

    wr(2'd0, 8'd0, "z_div", NO);
    wr(2'd1, 8'd0, "z_dead", NO);
    wr(2'd2, 8'd0, "z_azl", NO);
    wr(2'd3, 8'd1, "z_ctrl", NO);
    rd("rd_z_dead", 2'd1, 8'd0);
    step("z_idle", NO);
    en = 1'b1;
    step("z_e0", SO);
    step("z_ph1", P1 | CS | SO);
    step("z_gap1", SO);
    step("z_ph2", P2 | SO);
    step("z_gap2", SO);
    step("z_ph1n", P1 | CS | SO);
    az_req = 1'b1;
    step("z_acc", BZ);
    az_req = 1'b0;
    step("z_zero", AZ | BZ);
    step("z_recon", BZ);
    step("z_done", DN | SO | P1 | CS);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
